// File: rtl/ip_hdr_gen.sv
// IPv4 header generator: latches a request, checksums the 20-byte header and streams it MSB-first.
// Optional IP_HDR_ID_INC_EN: incrementing identification counter (otherwise id field is zero).
module ip_hdr_gen #(
  parameter int          DATA_W  = 64,
  parameter logic [15:0] ID_INIT = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [15:0]         req_frame_len,
  input  logic [7:0]          req_tos,
  input  logic [7:0]          req_ttl,
  input  logic [7:0]          req_protocol,
  input  logic [31:0]         req_saddr,
  input  logic [31:0]         req_daddr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic                err_len
);

  localparam int NB         = DATA_W / 8;
  localparam int BEATS      = (160 + DATA_W - 1) / DATA_W;
  localparam int LAST_BYTES = 20 - (BEATS - 1) * NB;
  localparam int PAD_W      = BEATS * DATA_W;
  localparam logic [2:0]    LAST_BEAT = 3'(BEATS - 1);
  localparam logic [NB-1:0] LAST_KEEP = ~({NB{1'b1}} >> LAST_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUM  = 2'd1;
  localparam logic [1:0] S_FOLD = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  logic [1:0]       state;
  logic [159:0]     hdr;
  logic [19:0]      sum;
  logic [19:0]      sum_c;
  logic [16:0]      fold1;
  logic [15:0]      fold2;
  logic [2:0]       beat;
  logic             short_q;
  logic             accept;
  logic             last_xfer;
  logic [15:0]      id_val;
  logic [PAD_W-1:0] pad;

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign out_valid = (state == S_EMIT) && !rst;
  assign last_xfer = out_valid && out_ready && (beat == LAST_BEAT);

`ifdef IP_HDR_ID_INC_EN
  logic [15:0] id_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      id_cnt <= ID_INIT;
    else if (last_xfer)
      id_cnt <= id_cnt + 16'd1;
  end

  assign id_val = id_cnt;
`else
  // id field fixed at zero; ID_INIT only seeds the counter build
  assign id_val = ID_INIT & 16'h0000;
`endif

  // check field (word 5) is still zero in hdr while summing
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < 10; i++)
      sum_c = sum_c + 20'(hdr[159 - 16*i -: 16]);
  end

  assign fold1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      hdr     <= '0;
      sum     <= '0;
      beat    <= '0;
      short_q <= 1'b0;
      err_len <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          hdr     <= {4'h4, 4'h5, req_tos, req_frame_len - 16'd18, id_val, 16'h0000,
                      req_ttl, req_protocol, 16'h0000, req_saddr, req_daddr};
          short_q <= (req_frame_len < 16'd38);
          err_len <= (req_frame_len < 16'd38);
          state   <= S_SUM;
        end
        S_SUM: begin
          sum   <= sum_c;
          state <= short_q ? S_IDLE : S_FOLD;
        end
        S_FOLD: begin
          hdr[79:64] <= ~fold2;
          beat       <= '0;
          state      <= S_EMIT;
        end
        default: if (out_ready) begin
          if (beat == LAST_BEAT)
            state <= S_IDLE;
          else
            beat <= beat + 3'd1;
        end
      endcase
    end
  end

  // header left-aligned in a whole number of beats, tail zero-padded
  always_comb begin
    pad = '0;
    pad[PAD_W-1 -: 160] = hdr;
  end

  assign out_data = out_valid ? pad[(BEATS - 1 - int'(beat)) * DATA_W +: DATA_W] : '0;
  assign out_last = out_valid && (beat == LAST_BEAT);
  assign out_keep = !out_valid ? '0 : (out_last ? LAST_KEEP : '1);

endmodule
